axi_read_arbiter: RTL and testbench

//  Two-master AXI4-Lite arbiter directly upstream of the address-decoding crossbar.

---
 rtl/axi_read_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_axi_read_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// Two-master AXI4-Lite read arbiter (IFU / LSU) with LSU write pass-through.
// Optional round-robin arbitration when ARB_RR_EN is defined; fixed LSU priority otherwise.
module axi_read_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    // IFU read
    input  logic                ifu_arvalid,
    input  logic [ADDR_W-1:0]   ifu_araddr,
    output logic                ifu_arready,
    output logic                ifu_rvalid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [1:0]          ifu_rresp,
    input  logic                ifu_rready,
    // LSU read
    input  logic                lsu_arvalid,
    input  logic [ADDR_W-1:0]   lsu_araddr,
    output logic                lsu_arready,
    output logic                lsu_rvalid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [1:0]          lsu_rresp,
    input  logic                lsu_rready,
    // LSU write
    input  logic                lsu_awvalid,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    output logic                lsu_awready,
    input  logic                lsu_wvalid,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic                lsu_wready,
    output logic                lsu_bvalid,
    output logic [1:0]          lsu_bresp,
    input  logic                lsu_bready,
    // downstream read
    output logic                arvalid,
    output logic [ADDR_W-1:0]   araddr,
    input  logic                arready,
    input  logic                rvalid,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    output logic                rready,
    // downstream write
    output logic                awvalid,
    output logic [ADDR_W-1:0]   awaddr,
    input  logic                awready,
    output logic                wvalid,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    input  logic                wready,
    input  logic                bvalid,
    input  logic [1:0]          bresp,
    output logic                bready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              grant;
    logic [ADDR_W-1:0] addr_q;
    logic              any_req;
    logic              win;
    logic              sel_rready;

    // request summary and granted master's rready
    always_comb begin
        any_req    = ifu_arvalid | lsu_arvalid;
        sel_rready = grant ? lsu_rready : ifu_rready;
    end

`ifdef ARB_RR_EN
    logic last_grant;

    // round-robin: on conflict the master that was not granted last wins
    always_comb begin
        win = (ifu_arvalid && lsu_arvalid) ? ~last_grant : lsu_arvalid;
    end

    // remember the most recent grant; reset to LSU so the IFU wins first
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_grant <= win;
        end
    end
`else
    // fixed priority: LSU wins whenever it requests
    always_comb begin
        win = lsu_arvalid;
    end
`endif

    // state register plus grant / address capture at acceptance
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            grant  <= 1'b0;
            addr_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                grant  <= win;
                addr_q <= win ? lsu_araddr : ifu_araddr;
            end
        end
    end

    // next-state logic of the read FSM
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any_req) state_nxt = ADDR;
            ADDR: if (arready) state_nxt = DATA;
            DATA: if (rvalid && sel_rready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // read-path outputs; everything idles low while reset is asserted
    always_comb begin
        ifu_arready = 1'b0;
        lsu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = 2'b00;
        lsu_rvalid  = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = 2'b00;
        arvalid     = 1'b0;
        araddr      = '0;
        rready      = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    ifu_arready = ifu_arvalid && !win;
                    lsu_arready = lsu_arvalid && win;
                end
                ADDR: begin
                    arvalid = 1'b1;
                    araddr  = addr_q;
                end
                DATA: begin
                    rready = sel_rready;
                    if (grant) begin
                        lsu_rvalid = rvalid;
                        lsu_rdata  = rdata;
                        lsu_rresp  = rresp;
                    end else begin
                        ifu_rvalid = rvalid;
                        ifu_rdata  = rdata;
                        ifu_rresp  = rresp;
                    end
                end
                default: begin
                    arvalid = 1'b0;
                end
            endcase
        end
    end

    // write channels are a stateless wire-through to the crossbar
    assign awvalid     = lsu_awvalid;
    assign awaddr      = lsu_awaddr;
    assign lsu_awready = awready;
    assign wvalid      = lsu_wvalid;
    assign wdata       = lsu_wdata;
    assign wstrb       = lsu_wstrb;
    assign lsu_wready  = wready;
    assign lsu_bvalid  = bvalid;
    assign lsu_bresp   = bresp;
    assign bready      = lsu_bready;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: directed scenarios plus random traffic
// against a transaction-level model; honours ARB_RR_EN when defined.
module tb_axi_read_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [1:0]  m_arv;
    logic [31:0] m_ara [2];
    logic [1:0]  m_rr;
    logic        ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid;
    logic [31:0] ifu_rdata, lsu_rdata;
    logic [1:0]  ifu_rresp, lsu_rresp;

    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready;
    logic        lsu_bvalid, lsu_bready;
    logic [31:0] lsu_awaddr, lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic [1:0]  lsu_bresp;

    logic        arvalid, arready, rvalid, rready;
    logic [31:0] araddr, rdata;
    logic [1:0]  rresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] awaddr, wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;

    axi_read_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .ifu_arvalid(m_arv[0]), .ifu_araddr(m_ara[0]), .ifu_arready(ifu_arready),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
        .ifu_rready(m_rr[0]),
        .lsu_arvalid(m_arv[1]), .lsu_araddr(m_ara[1]), .lsu_arready(lsu_arready),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
        .lsu_rready(m_rr[1]),
        .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awready(lsu_awready),
        .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_wready(lsu_wready), .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp),
        .lsu_bready(lsu_bready),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
        .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
        .bvalid(bvalid), .bresp(bresp), .bready(bready)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // transaction-level model of the arbiter
    bit          busy, owner, ardone, last_g;
    logic [31:0] out_addr;
    logic [31:0] ar_log [$];
    logic [31:0] got_data [2];
    logic [1:0]  got_resp [2];
    int          stall_cnt;

    // master / slave environment state
    logic [31:0] mq [2][$];
    bit          hs_ar [2];
    int          rr_mode [2];
    int          rr_hold [2];
    int          ar_lat, ar_cnt, r_lat, r_lat_cur, r_cnt;
    bit          s_pend;
    logic [31:0] s_addr;
    bit          wr_rand;

    function automatic logic [31:0] sdata(input logic [31:0] a);
        return (a == 32'h3000_0000) ? 32'hdead_beef : (a ^ 32'h5a5a_c3c3);
    endfunction

    function automatic logic [1:0] sresp(input logic [31:0] a);
        return a[5:4];
    endfunction

    function automatic logic o_arready(input int m);
        return m != 0 ? lsu_arready : ifu_arready;
    endfunction

    function automatic logic o_rvalid(input int m);
        return m != 0 ? lsu_rvalid : ifu_rvalid;
    endfunction

    function automatic logic [31:0] o_rdata(input int m);
        return m != 0 ? lsu_rdata : ifu_rdata;
    endfunction

    function automatic logic [1:0] o_rresp(input int m);
        return m != 0 ? lsu_rresp : ifu_rresp;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int m = 0; m < 2; m++) begin
            if (hs_ar[m]) begin
                m_arv[m] = 1'b0;
                m_ara[m] = $urandom;
                hs_ar[m] = 1'b0;
            end
            if (reset) begin
                m_arv[m] = 1'b0;
            end else if (!m_arv[m] && mq[m].size() > 0) begin
                m_arv[m] = 1'b1;
                m_ara[m] = mq[m].pop_front();
            end
            if (rr_mode[m] == 1) m_rr[m] = 1'($urandom % 2);
            else m_rr[m] = (rr_hold[m] > 0) ? 1'b0 : 1'b1;
        end
        if (ar_lat < 0) arready = 1'($urandom % 2);
        else arready = arvalid && (ar_cnt >= ar_lat);
        if (s_pend && r_cnt >= r_lat_cur) begin
            rvalid = 1'b1;
            rdata  = sdata(s_addr);
            rresp  = sresp(s_addr);
        end else begin
            rvalid = 1'b0;
            rdata  = $urandom;
            rresp  = 2'($urandom);
        end
        if (wr_rand) begin
            lsu_awvalid = 1'($urandom); lsu_awaddr = $urandom;
            lsu_wvalid  = 1'($urandom); lsu_wdata  = $urandom;
            lsu_wstrb   = 4'($urandom); lsu_bready = 1'($urandom);
            awready = 1'($urandom); wready = 1'($urandom);
            bvalid  = 1'($urandom); bresp  = 2'($urandom);
        end
    endtask

    task automatic model_reset();
        busy = 0; ardone = 0; last_g = 1; owner = 0;
        s_pend = 0; ar_cnt = 0; r_cnt = 0;
        for (int m = 0; m < 2; m++) begin
            hs_ar[m] = 0;
            rr_hold[m] = 0;
        end
    endtask

    task automatic check_cycle();
        bit win, any, b, in_data, exp_arv;
        b       = busy;
        any     = |m_arv;
        exp_arv = busy && !ardone;
        in_data = busy && ardone;
        chk("arvalid", arvalid, exp_arv);
        chk("araddr", araddr, exp_arv ? out_addr : 32'h0);
        for (int m = 0; m < 2; m++) begin
            if (in_data && owner == m) begin
                chk($sformatf("m%0d_rvalid", m), o_rvalid(m), rvalid);
                chk($sformatf("m%0d_rdata", m), o_rdata(m), rdata);
                chk($sformatf("m%0d_rresp", m), o_rresp(m), rresp);
            end else begin
                chk($sformatf("m%0d_rvalid_idle", m), o_rvalid(m), 0);
                chk($sformatf("m%0d_rdata_idle", m), o_rdata(m), 0);
                chk($sformatf("m%0d_rresp_idle", m), o_rresp(m), 0);
            end
            if (o_rvalid(m) && rr_hold[m] > 0) rr_hold[m]--;
        end
        chk("rready", rready, in_data ? m_rr[owner] : 1'b0);
        chk("awvalid", awvalid, lsu_awvalid);
        chk("awaddr", awaddr, lsu_awaddr);
        chk("wvalid", wvalid, lsu_wvalid);
        chk("wdata", wdata, lsu_wdata);
        chk("wstrb", wstrb, lsu_wstrb);
        chk("bready", bready, lsu_bready);
        chk("lsu_awready", lsu_awready, awready);
        chk("lsu_wready", lsu_wready, wready);
        chk("lsu_bvalid", lsu_bvalid, bvalid);
        chk("lsu_bresp", lsu_bresp, bresp);
        if (exp_arv) begin
            if (arready) begin
                ardone = 1; s_pend = 1; s_addr = araddr; r_cnt = 0; ar_cnt = 0;
                r_lat_cur = (r_lat < 0) ? int'($urandom % 4) : r_lat;
                ar_log.push_back(araddr);
            end else begin
                ar_cnt++;
            end
        end
        if (s_pend && !rvalid) r_cnt++;
        if (in_data && rvalid && !rready) stall_cnt++;
        if (in_data && rvalid && m_rr[owner]) begin
            chk("rdata_e2e", o_rdata(owner), sdata(out_addr));
            chk("rresp_e2e", o_rresp(owner), sresp(out_addr));
            got_data[owner] = o_rdata(owner);
            got_resp[owner] = o_rresp(owner);
            busy = 0; ardone = 0; s_pend = 0;
        end
        if (!b) begin
`ifdef ARB_RR_EN
            win = (m_arv == 2'b11) ? !last_g : m_arv[1];
`else
            win = m_arv[1];
`endif
            chk("ifu_arready", ifu_arready, any && !win);
            chk("lsu_arready", lsu_arready, any && win);
            if (any) begin
                busy = 1; ardone = 0; owner = win;
                out_addr = m_ara[win];
                hs_ar[win] = 1;
                last_g = win;
            end
        end else begin
            chk("ifu_arready_busy", o_arready(0), 0);
            chk("lsu_arready_busy", o_arready(1), 0);
        end
    endtask

    task automatic tick();
        drive();
        @(negedge clock);
        if (reset) model_reset();
        else check_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic run_until_idle(input int max);
        int n;
        n = 0;
        while ((mq[0].size() + mq[1].size() > 0 || m_arv != 2'b00 || busy) && n < max) begin
            tick();
            n++;
        end
        chk("drain_in_budget", n < max, 1'b1);
    endtask

    initial begin
        m_arv = 2'b00; m_rr = 2'b11;
        m_ara[0] = '0; m_ara[1] = '0;
        rr_mode[0] = 0; rr_mode[1] = 0;
        ar_lat = 0; r_lat = 0; r_lat_cur = 0; wr_rand = 1;
        stall_cnt = 0;
        model_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset_arvalid", arvalid, 0);
        chk("reset_rready", rready, 0);

        // single IFU read, slave arready after two cycles
        ar_lat = 2; r_lat = 1; got_data[0] = '0;
        mq[0].push_back(32'h3000_0000);
        run_until_idle(50);
        chk("t1_ifu_rdata", got_data[0], 32'hdead_beef);
        chk("t1_ifu_rresp", got_resp[0], 2'b00);

        // simultaneous requests
        pulse_reset();
        ar_lat = 0; r_lat = 0;
        ar_log.delete();
        mq[0].push_back(32'h3000_0004);
        mq[1].push_back(32'h8000_0000);
        run_until_idle(50);
        chk("t2_count", ar_log.size(), 2);
`ifdef ARB_RR_EN
        chk("t2_first", ar_log[0], 32'h3000_0004);
        chk("t2_second", ar_log[1], 32'h8000_0000);
`else
        chk("t2_first", ar_log[0], 32'h8000_0000);
        chk("t2_second", ar_log[1], 32'h3000_0004);
`endif

        // IFU back-pressure for three cycles with LSU waiting
        rr_hold[0] = 3; stall_cnt = 0;
        ar_log.delete();
        mq[0].push_back(32'h3000_0008);
        tick();
        tick();
        mq[1].push_back(32'h8000_0010);
        run_until_idle(50);
        chk("t3_stall_cycles", stall_cnt, 3);
        chk("t3_order_count", ar_log.size(), 2);
        chk("t3_lsu_after", ar_log[1], 32'h8000_0010);

        // LSU write overlapping an IFU read
        wr_rand = 0;
        lsu_awvalid = 1; lsu_awaddr = 32'h1000_0000;
        lsu_wvalid = 1; lsu_wdata = 32'h41; lsu_wstrb = 4'b0001;
        lsu_bready = 1; awready = 1; wready = 1; bvalid = 1; bresp = 2'b00;
        ar_lat = 1; r_lat = 3; got_data[0] = '0;
        mq[0].push_back(32'h3000_0000);
        run_until_idle(50);
        chk("t4_ifu_rdata", got_data[0], 32'hdead_beef);
        wr_rand = 1;

        // reset in ADDR, then in DATA
        ar_lat = 5; r_lat = 0;
        mq[0].push_back(32'h3000_0010);
        tick();
        tick();
        chk("t5_in_addr", arvalid, 1);
        pulse_reset();
        tick();
        chk("t5a_arvalid", arvalid, 0);
        chk("t5a_ifu_arready", ifu_arready, 0);
        ar_lat = 0; r_lat = 8;
        mq[0].push_back(32'h3000_0014);
        tick();
        tick();
        tick();
        chk("t5_in_data", busy && ardone, 1);
        pulse_reset();
        tick();
        chk("t5b_arvalid", arvalid, 0);
        chk("t5b_rready", rready, 0);
        chk("t5b_ifu_rvalid", ifu_rvalid, 0);
        chk("t5b_lsu_rvalid", lsu_rvalid, 0);
        r_lat = 1; got_data[0] = '0;
        mq[0].push_back(32'h3000_0000);
        run_until_idle(50);
        chk("t5_after_rdata", got_data[0], 32'hdead_beef);

        // error response to an LSU read
        got_resp[1] = 2'b00;
        mq[1].push_back(32'h9000_0020);
        run_until_idle(50);
        chk("t6_lsu_rresp", got_resp[1], 2'b10);
        chk("t6_lsu_rdata", got_data[1], 32'h9000_0020 ^ 32'h5a5a_c3c3);

        // random traffic
        ar_lat = -1; r_lat = -1;
        rr_mode[0] = 1; rr_mode[1] = 1;
        for (int i = 0; i < 400; i++) begin
            for (int m = 0; m < 2; m++) begin
                if (mq[m].size() < 2 && $urandom % 4 == 0) mq[m].push_back($urandom);
            end
            if (i == 200) pulse_reset();
            else tick();
        end
        run_until_idle(400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
